// File: rtl/stream_asyn_fifo_framer_if.sv
// Stream-side and controller-side signal bundle of the write-domain framer.
//   s_valid/s_ready/s_data/s_sop/s_eop/s_err : upstream beat stream
//   w_full                                   : controller full flag
//   w_ctrl/w_data                            : command and RAM write data to the controller
// Modport master: the environment (packet source plus write controller).
// Modport slave : the framer itself.
interface stream_asyn_fifo_framer_if #(
    parameter int DATAWIDTH = 32
);
    logic                 s_valid;
    logic                 s_ready;
    logic [DATAWIDTH-1:0] s_data;
    logic                 s_sop;
    logic                 s_eop;
    logic                 s_err;
    logic                 w_full;
    logic [2:0]           w_ctrl;
    logic [DATAWIDTH-1:0] w_data;

    modport master (
        output s_valid, s_data, s_sop, s_eop, s_err, w_full,
        input  s_ready, w_ctrl, w_data
    );

    modport slave (
        input  s_valid, s_data, s_sop, s_eop, s_err, w_full,
        output s_ready, w_ctrl, w_data
    );
endinterface

// File: rtl/stream_asyn_fifo_framer.sv
// Write-domain command initiator for the stream async FIFO write controller.
// Turns a valid/ready beat stream with sop/eop/err markers into the 3-bit
// w_ctrl command stream plus RAM write data, appends HEADSIZE header words
// per committed frame, discards errored/oversize/unterminated frames and
// keeps saturating commit/drop statistics.
// Ports:
//   w_clk, w_rst_n : write clock, asynchronous active-low reset
//   bus (slave)    : s_valid/s_ready/s_data/s_sop/s_eop/s_err, w_full, w_ctrl, w_data
//   frm_cnt        : committed frames (saturating)
//   drop_cnt       : discarded frames (saturating)
module stream_asyn_fifo_framer #(
    parameter int DATAWIDTH = 32,
    parameter int HEADSIZE  = 1,
    parameter int LENWIDTH  = 16,
    parameter int MAXLEN    = 1500,
    parameter int CNTWIDTH  = 16
) (
    input  logic                       w_clk,
    input  logic                       w_rst_n,
    stream_asyn_fifo_framer_if.slave   bus,
    output logic [CNTWIDTH-1:0]        frm_cnt,
    output logic [CNTWIDTH-1:0]        drop_cnt
);
    localparam logic [2:0] CMD_NOP     = 3'd0;
    localparam logic [2:0] CMD_WRITE   = 3'd1;
    localparam logic [2:0] CMD_EOF_WR  = 3'd2;
    localparam logic [2:0] CMD_HEAD    = 3'd4;
    localparam logic [2:0] CMD_FHEAD   = 3'd5;
    localparam logic [2:0] CMD_DISCARD = 3'd6;

    localparam int HIW = (HEADSIZE > 1) ? $clog2(HEADSIZE) : 1;
    localparam logic [HIW-1:0]      HDR_LAST = HIW'((HEADSIZE > 0) ? HEADSIZE - 1 : 0);
    localparam logic [LENWIDTH-1:0] MAX_L    = LENWIDTH'(MAXLEN);

    typedef enum logic [1:0] {ST_DATA = 2'd0, ST_HDR = 2'd1, ST_DROP = 2'd2} state_t;

    state_t                state_q,     state_d;
    logic [LENWIDTH-1:0]   frame_len_q, frame_len_d;
    logic [LENWIDTH-1:0]   len_q,       len_d;
    logic [LENWIDTH-1:0]   seq_q,       seq_d;
    logic [HIW-1:0]        hdr_idx_q,   hdr_idx_d;
    logic [CNTWIDTH-1:0]   frm_cnt_q,   frm_cnt_d;
    logic [CNTWIDTH-1:0]   drop_cnt_q,  drop_cnt_d;
    logic                  ready_s;
    logic [2:0]            ctrl_s;
    logic [DATAWIDTH-1:0]  data_s;

    function automatic logic [CNTWIDTH-1:0] sat_inc(input logic [CNTWIDTH-1:0] v);
        sat_inc = (&v) ? v : v + CNTWIDTH'(1);
    endfunction

    // Next-state and command decode from registered state, stream and full flag.
    always_comb begin
        state_d     = state_q;
        frame_len_d = frame_len_q;
        len_d       = len_q;
        seq_d       = seq_q;
        hdr_idx_d   = hdr_idx_q;
        frm_cnt_d   = frm_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        ready_s     = 1'b0;
        ctrl_s      = CMD_NOP;
        data_s      = {DATAWIDTH{1'b0}};
        case (state_q)
            ST_DATA: begin
                // A sop inside an open frame closes the old frame as a drop;
                // the discard needs no RAM space, so it goes out even when full.
                if (bus.s_valid && bus.s_sop && (frame_len_q != {LENWIDTH{1'b0}})) begin
                    ctrl_s      = CMD_DISCARD;
                    frame_len_d = {LENWIDTH{1'b0}};
                    drop_cnt_d  = sat_inc(drop_cnt_q);
                end else begin
                    ready_s = !bus.w_full;
                    if (bus.s_valid && !bus.w_full) begin
                        if (frame_len_q == MAX_L) begin
                            // Beat MAXLEN+1: abandon the frame, swallow the rest.
                            ctrl_s      = CMD_DISCARD;
                            frame_len_d = {LENWIDTH{1'b0}};
                            drop_cnt_d  = sat_inc(drop_cnt_q);
                            if (!bus.s_eop) begin
                                state_d = ST_DROP;
                            end else begin
                                state_d = ST_DATA;
                            end
                        end else if (bus.s_eop && bus.s_err) begin
                            ctrl_s      = CMD_DISCARD;
                            frame_len_d = {LENWIDTH{1'b0}};
                            drop_cnt_d  = sat_inc(drop_cnt_q);
                        end else if (bus.s_eop) begin
                            ctrl_s      = CMD_EOF_WR;
                            data_s      = bus.s_data;
                            len_d       = frame_len_q + LENWIDTH'(1);
                            frame_len_d = {LENWIDTH{1'b0}};
                            if (HEADSIZE == 0) begin
                                frm_cnt_d = sat_inc(frm_cnt_q);
                            end else begin
                                state_d = ST_HDR;
                            end
                        end else begin
                            ctrl_s      = CMD_WRITE;
                            data_s      = bus.s_data;
                            frame_len_d = frame_len_q + LENWIDTH'(1);
                        end
                    end else begin
                        ctrl_s = CMD_NOP;
                    end
                end
            end
            ST_HDR: begin
                if (!bus.w_full) begin
                    // Word 0 carries the length, later words the sequence number.
                    if (hdr_idx_q == {HIW{1'b0}}) begin
                        data_s = DATAWIDTH'(len_q);
                    end else begin
                        data_s = DATAWIDTH'(seq_q);
                    end
                    if (hdr_idx_q == HDR_LAST) begin
                        ctrl_s    = CMD_FHEAD;
                        hdr_idx_d = {HIW{1'b0}};
                        seq_d     = seq_q + LENWIDTH'(1);
                        frm_cnt_d = sat_inc(frm_cnt_q);
                        state_d   = ST_DATA;
                    end else begin
                        ctrl_s    = CMD_HEAD;
                        hdr_idx_d = hdr_idx_q + HIW'(1);
                    end
                end else begin
                    ctrl_s = CMD_NOP;
                end
            end
            ST_DROP: begin
                // Beats are consumed without touching the controller.
                ready_s = 1'b1;
                if (bus.s_valid && bus.s_eop) begin
                    state_d     = ST_DATA;
                    frame_len_d = {LENWIDTH{1'b0}};
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d     = ST_DATA;
                frame_len_d = {LENWIDTH{1'b0}};
                hdr_idx_d   = {HIW{1'b0}};
            end
        endcase
    end

    // State, length, header and statistics registers.
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q     <= ST_DATA;
            frame_len_q <= {LENWIDTH{1'b0}};
            len_q       <= {LENWIDTH{1'b0}};
            seq_q       <= {LENWIDTH{1'b0}};
            hdr_idx_q   <= {HIW{1'b0}};
            frm_cnt_q   <= {CNTWIDTH{1'b0}};
            drop_cnt_q  <= {CNTWIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            frame_len_q <= frame_len_d;
            len_q       <= len_d;
            seq_q       <= seq_d;
            hdr_idx_q   <= hdr_idx_d;
            frm_cnt_q   <= frm_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // The controller shares w_rst_n, so hold everything quiet while it is low.
    assign bus.s_ready = w_rst_n & ready_s;
    assign bus.w_ctrl  = w_rst_n ? ctrl_s : CMD_NOP;
    assign bus.w_data  = w_rst_n ? data_s : {DATAWIDTH{1'b0}};
    assign frm_cnt     = frm_cnt_q;
    assign drop_cnt    = drop_cnt_q;
endmodule

// File: tb/tb_stream_asyn_fifo_framer.sv
module tb_stream_asyn_fifo_framer;
    localparam int DW = 32;
    localparam int HS = 3;
    localparam int LW = 16;
    localparam int ML = 4;
    localparam int CW = 4;
    localparam int CNT_MAX = 15;

    typedef struct packed {
        logic [2:0]  ctrl;
        logic [31:0] data;
    } cmd_t;

    logic w_clk;
    logic w_rst_n;
    logic [CW-1:0] frm_cnt;
    logic [CW-1:0] drop_cnt;

    stream_asyn_fifo_framer_if #(.DATAWIDTH(DW)) bus_if ();

    stream_asyn_fifo_framer #(
        .DATAWIDTH(DW), .HEADSIZE(HS), .LENWIDTH(LW), .MAXLEN(ML), .CNTWIDTH(CW)
    ) dut (
        .w_clk   (w_clk),
        .w_rst_n (w_rst_n),
        .bus     (bus_if),
        .frm_cnt (frm_cnt),
        .drop_cnt(drop_cnt)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: expected command stream and frame statistics.
    cmd_t        exp_q[$];
    int          frm_m  = 0;
    int          drop_m = 0;
    logic [15:0] seq_m  = 16'd0;
    logic [31:0] beat_d [0:7];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CNT_MAX) ? CNT_MAX : v;
    endfunction

    function automatic bit is_write(input logic [2:0] c);
        return (c == 3'd1) || (c == 3'd2) || (c == 3'd4) || (c == 3'd5);
    endfunction

    task automatic push(input logic [2:0] c, input logic [31:0] d);
        cmd_t e;
        e.ctrl = c;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Frame-level expectation: what the controller must see for this frame.
    task automatic model_frame(input int n, input bit has_eop, input bit err);
        if (!has_eop) begin
            for (int i = 0; i < n; i++) push(3'd1, beat_d[i]);
            push(3'd6, 32'd0);
            drop_m++;
        end else if (n > ML) begin
            for (int i = 0; i < ML; i++) push(3'd1, beat_d[i]);
            push(3'd6, 32'd0);
            drop_m++;
        end else if (err) begin
            for (int i = 0; i < n - 1; i++) push(3'd1, beat_d[i]);
            push(3'd6, 32'd0);
            drop_m++;
        end else begin
            for (int i = 0; i < n - 1; i++) push(3'd1, beat_d[i]);
            push(3'd2, beat_d[n-1]);
            for (int h = 0; h < HS; h++)
                push((h == HS - 1) ? 3'd5 : 3'd4, (h == 0) ? 32'(n) : 32'(seq_m));
            seq_m = seq_m + 16'd1;
            frm_m++;
        end
    endtask

    // Command monitor: every issued command must match the model in order.
    always @(negedge w_clk) begin
        if (bus_if.w_full) check_eq("no_write_while_full", 64'(is_write(bus_if.w_ctrl)), 64'd0);
        if (bus_if.w_ctrl != 3'd0) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_cmd", 64'(bus_if.w_ctrl), 64'd0);
            end else begin
                cmd_t e;
                e = exp_q.pop_front();
                check_eq("cmd", 64'(bus_if.w_ctrl), 64'(e.ctrl));
                if (is_write(e.ctrl)) check_eq("cmd_data", 64'(bus_if.w_data), 64'(e.data));
            end
        end
    end

    // Drive one frame beat by beat; beats at index >= full_from see w_full=1.
    task automatic send_frame(input int n, input bit has_eop, input bit err, input bit sopf,
                              input int full_from, input bit rnd_full);
        for (int i = 0; i < n; i++) beat_d[i] = $urandom;
        model_frame(n, has_eop, err);
        for (int i = 0; i < n; i++) begin
            bit acc;
            int waited;
            acc = 1'b0;
            waited = 0;
            while (!acc) begin
                @(posedge w_clk); #1;
                bus_if.s_valid = 1'b1;
                bus_if.s_data  = beat_d[i];
                bus_if.s_sop   = (i == 0) && sopf;
                bus_if.s_eop   = has_eop && (i == n - 1);
                bus_if.s_err   = (has_eop && (i == n - 1)) ? err : 1'($urandom_range(0, 1));
                bus_if.w_full  = (i >= full_from) ? 1'b1
                               : (rnd_full ? ($urandom_range(0, 3) == 0) : 1'b0);
                @(negedge w_clk);
                acc = bus_if.s_valid && bus_if.s_ready;
                if (i >= full_from) check_eq("drop_ready", 64'(bus_if.s_ready), 64'd1);
                waited++;
                if (!acc && waited > 200) begin
                    check_eq("beat_timeout", 64'(acc), 64'd1);
                    acc = 1'b1;
                end
            end
        end
    endtask

    task automatic idle_check();
        @(posedge w_clk); #1;
        bus_if.s_valid = 1'b0;
        bus_if.s_sop   = 1'b0;
        bus_if.s_eop   = 1'b0;
        bus_if.w_full  = 1'b0;
        repeat (HS + 3) begin @(posedge w_clk); #1; end
        @(negedge w_clk);
        check_eq("frm_cnt", 64'(frm_cnt), 64'(sat(frm_m)));
        check_eq("drop_cnt", 64'(drop_cnt), 64'(sat(drop_m)));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1);
    end

    initial begin
        bit prev_trunc;
        w_rst_n        = 1'b0;
        bus_if.s_valid = 1'b1;
        bus_if.s_data  = 32'hDEAD_BEEF;
        bus_if.s_sop   = 1'b1;
        bus_if.s_eop   = 1'b0;
        bus_if.s_err   = 1'b0;
        bus_if.w_full  = 1'b0;
        repeat (2) @(negedge w_clk);
        check_eq("rst_s_ready", 64'(bus_if.s_ready), 64'd0);
        check_eq("rst_w_ctrl", 64'(bus_if.w_ctrl), 64'd0);
        check_eq("rst_w_data", 64'(bus_if.w_data), 64'd0);
        check_eq("rst_frm_cnt", 64'(frm_cnt), 64'd0);
        check_eq("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        @(posedge w_clk); #1;
        bus_if.s_valid = 1'b0;
        w_rst_n = 1'b1;
        idle_check();

        // Clean 4-beat frame, then a 2-beat frame with random stalls.
        send_frame(4, 1'b1, 1'b0, 1'b1, 99, 1'b0);
        idle_check();
        send_frame(2, 1'b1, 1'b0, 1'b1, 99, 1'b1);
        idle_check();
        // Errored frame.
        send_frame(3, 1'b1, 1'b1, 1'b1, 99, 1'b0);
        idle_check();
        // Oversize frame: beats 6..7 arrive while full and must still be consumed.
        send_frame(7, 1'b1, 1'b0, 1'b1, 5, 1'b0);
        send_frame(2, 1'b1, 1'b0, 1'b1, 99, 1'b0);
        idle_check();
        // Missing eop: a sop on the third beat closes the open frame.
        send_frame(2, 1'b0, 1'b0, 1'b1, 99, 1'b0);
        send_frame(2, 1'b1, 1'b0, 1'b1, 99, 1'b0);
        idle_check();

        // Full held for 5 cycles with a pending beat.
        @(posedge w_clk); #1;
        bus_if.s_valid = 1'b1;
        bus_if.s_sop   = 1'b1;
        bus_if.s_eop   = 1'b0;
        bus_if.w_full  = 1'b1;
        repeat (5) begin
            @(negedge w_clk);
            check_eq("full_s_ready", 64'(bus_if.s_ready), 64'd0);
            check_eq("full_w_ctrl", 64'(bus_if.w_ctrl), 64'd0);
        end
        idle_check();

        // Randomized frames; counters saturate along the way.
        prev_trunc = 1'b0;
        for (int f = 0; f < 70; f++) begin
            int  n;
            bit  trunc;
            bit  err;
            n     = $urandom_range(1, 7);
            trunc = (f != 69) && ($urandom_range(0, 5) == 0);
            err   = ($urandom_range(0, 4) == 0);
            if (trunc && n > ML) n = ML;
            send_frame(n, !trunc, err, prev_trunc ? 1'b1 : 1'($urandom_range(0, 1)), 99, 1'b1);
            prev_trunc = trunc;
            if (!trunc && ($urandom_range(0, 2) == 0)) idle_check();
        end
        idle_check();

        // Reset while the header is being written.
        send_frame(2, 1'b1, 1'b0, 1'b1, 99, 1'b0);
        @(posedge w_clk); #1;
        w_rst_n = 1'b0;
        exp_q.delete();
        frm_m  = 0;
        drop_m = 0;
        seq_m  = 16'd0;
        @(negedge w_clk);
        check_eq("midhdr_rst_s_ready", 64'(bus_if.s_ready), 64'd0);
        check_eq("midhdr_rst_w_ctrl", 64'(bus_if.w_ctrl), 64'd0);
        check_eq("midhdr_rst_w_data", 64'(bus_if.w_data), 64'd0);
        check_eq("midhdr_rst_frm", 64'(frm_cnt), 64'd0);
        check_eq("midhdr_rst_drop", 64'(drop_cnt), 64'd0);
        @(posedge w_clk); #1;
        bus_if.s_valid = 1'b0;
        w_rst_n = 1'b1;
        @(negedge w_clk);
        check_eq("post_rst_w_ctrl", 64'(bus_if.w_ctrl), 64'd0);
        check_eq("post_rst_frm", 64'(frm_cnt), 64'd0);
        send_frame(3, 1'b1, 1'b0, 1'b1, 99, 1'b1);
        idle_check();

        check_eq("exp_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
